jtkicker_romarb: RTL and testbench

JTKICKER_ROMARB -- requirements
Module: jtkicker_romarb

---
 rtl/jtkicker_romarb.sv | 135 +++++++++++++
 tb/tb_jtkicker_romarb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_romarb.sv
// Two-requester ROM arbiter sharing one SDRAM port, one cached word per requester.
// Define JTKICKER_ARB_RR_EN for round-robin instead of fixed priority on contention.
module jtkicker_romarb #(
   parameter int AW    = 13,
   parameter bit BANK1 = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] obj_addr,
   input  logic          obj_cs,
   output logic          obj_ok,
   output logic [31:0]   obj_data,
   input  logic [AW-1:0] scr_addr,
   input  logic          scr_cs,
   output logic          scr_ok,
   output logic [31:0]   scr_data,
   output logic [AW:0]   rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [31:0]   rom_data
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT0,
      WAIT1,
      GAP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_first;
   logic          r_cs;
   logic [AW:0]   r_raddr;
   logic          r_valid0;
   logic          r_valid1;
   logic [AW-1:0] r_addr0;
   logic [AW-1:0] r_addr1;
   logic [31:0]   r_data0;
   logic [31:0]   r_data1;
   logic          w_pend0;
   logic          w_pend1;
   logic          w_pick1;
   logic          w_grant;
   logic          w_done;
`ifdef JTKICKER_ARB_RR_EN
   logic          r_last;
`endif

   assign obj_ok   = obj_cs & r_valid0 & (obj_addr == r_addr0);
   assign scr_ok   = scr_cs & r_valid1 & (scr_addr == r_addr1);
   assign obj_data = r_data0;
   assign scr_data = r_data1;
   assign rom_cs   = r_cs;
   assign rom_addr = r_raddr;

   assign w_pend0 = obj_cs & ~obj_ok;
   assign w_pend1 = scr_cs & ~scr_ok;

`ifdef JTKICKER_ARB_RR_EN
   // on contention, serve whoever was not granted last
   assign w_pick1 = w_pend1 & (~w_pend0 | ~r_last);
`else
   assign w_pick1 = w_pend1 & ~w_pend0;
`endif

   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pend0 | w_pend1) begin
               w_grant = 1'b1;
               w_next  = w_pick1 ? WAIT1 : WAIT0;
            end
         end
         WAIT0, WAIT1: begin
            // first wait cycle carries the previous address's ack
            if (!r_first && rom_ok) begin
               w_done = 1'b1;
               w_next = GAP;
            end
         end
         GAP: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_first  <= 1'b0;
         r_cs     <= 1'b0;
         r_raddr  <= '0;
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         r_addr0  <= '0;
         r_addr1  <= '0;
         r_data0  <= '0;
         r_data1  <= '0;
`ifdef JTKICKER_ARB_RR_EN
         r_last   <= 1'b1;
`endif
      end else begin
         r_state <= w_next;
         r_first <= w_grant;
         if (w_grant) begin
            r_cs <= 1'b1;
            if (w_pick1) begin
               r_raddr  <= {BANK1, scr_addr};
               r_addr1  <= scr_addr;
               r_valid1 <= 1'b0;
            end else begin
               r_raddr  <= {~BANK1, obj_addr};
               r_addr0  <= obj_addr;
               r_valid0 <= 1'b0;
            end
`ifdef JTKICKER_ARB_RR_EN
            r_last <= w_pick1;
`endif
         end
         if (w_done) begin
            r_cs <= 1'b0;
            if (r_state == WAIT1) begin
               r_data1  <= rom_data;
               r_valid1 <= 1'b1;
            end else begin
               r_data0  <= rom_data;
               r_valid0 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Bench for jtkicker_romarb: directed scenarios plus random traffic against
// a transaction-level cache/arbitration model and a latency-programmable SDRAM.
module tb_jtkicker_romarb;
   localparam int AW = 13;
   localparam bit B1 = 1'b1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] obj_addr = '0;
   logic [AW-1:0] scr_addr = '0;
   logic          obj_cs = 1'b0;
   logic          scr_cs = 1'b0;
   logic          obj_ok, scr_ok, rom_cs;
   logic [31:0]   obj_data, scr_data;
   logic [31:0]   rom_data = '0;
   logic          rom_ok = 1'b0;
   logic [AW:0]   rom_addr;

   int ncmp = 0;
   int nerr = 0;

   always #10 clk = ~clk;

   jtkicker_romarb #(.AW(AW), .BANK1(B1)) dut (
      .clk(clk), .rst(rst),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_ok(obj_ok), .obj_data(obj_data),
      .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_ok(scr_ok), .scr_data(scr_data),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data)
   );

   // reference model state
   bit            m_val[2];
   logic [AW-1:0] m_addr[2];
   logic [31:0]   m_data[2];
   int            m_last;
   int            fly;
   logic [AW-1:0] fly_addr;
   bit            ack_seen;
   int            cnt;
   int            lat = 4;
   bit            stale = 1'b0;
   bit            p_cs;
   logic [AW:0]   p_addr;
   int            n_rise = 0;
   logic [AW:0]   rise_addr;

   function automatic logic [31:0] memfn(input logic [AW:0] a);
      return {a[7:0], ~a[7:0], 2'b01, a} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      ncmp++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         m_val[i]  = 1'b0;
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      m_last   = 1;
      fly      = -1;
      ack_seen = 1'b0;
      cnt      = 0;
      rom_ok   = 1'b0;
      p_cs     = 1'b0;
      p_addr   = '0;
   endtask

   task automatic step();
      bit pd[2];
      int w;
      int arb;
      logic [AW:0] ea;
      @(posedge clk);
      #1;
      pd[0] = obj_cs && !(m_val[0] && m_addr[0] == obj_addr);
      pd[1] = scr_cs && !(m_val[1] && m_addr[1] == scr_addr);
      if (ack_seen) begin
         ack_seen = 1'b0;
         chk("cs_fall", rom_cs, 0);
         if (fly >= 0) begin
            m_val[fly]  = 1'b1;
            m_addr[fly] = fly_addr;
            m_data[fly] = memfn(fly == 1 ? {B1, fly_addr} : {~B1, fly_addr});
         end
         fly = -1;
      end
      if (rom_cs && !p_cs) begin
`ifdef JTKICKER_ARB_RR_EN
         arb = (m_last == 1) ? 0 : 1;
`else
         arb = 0;
`endif
         w  = (pd[0] && pd[1]) ? arb : (pd[1] ? 1 : 0);
         ea = w == 1 ? {B1, scr_addr} : {~B1, obj_addr};
         chk("rise_pend", pd[0] || pd[1], 1);
         chk("rise_busy", fly, -1);
         chk("rise_addr", rom_addr, ea);
         m_val[w]  = 1'b0;
         fly       = w;
         fly_addr  = w == 1 ? scr_addr : obj_addr;
         m_last    = w;
         n_rise++;
         rise_addr = rom_addr;
      end
      if (rom_cs && p_cs) chk("addr_hold", rom_addr, p_addr);
      // SDRAM: ack after lat cycles of cs, optional stale ack on the first
      if (rom_cs) cnt++;
      else cnt = 0;
      rom_ok   = rom_cs && (cnt == lat || (stale && cnt == 1));
      rom_data = (rom_cs && cnt == lat) ? memfn(rom_addr) : $urandom;
      if (rom_cs && cnt == lat) ack_seen = 1'b1;
      chk("obj_ok", obj_ok, obj_cs && m_val[0] && m_addr[0] == obj_addr);
      chk("scr_ok", scr_ok, scr_cs && m_val[1] && m_addr[1] == scr_addr);
      if (m_val[0]) chk("obj_data", obj_data, m_data[0]);
      if (m_val[1]) chk("scr_data", scr_data, m_data[1]);
      p_cs   = rom_cs;
      p_addr = rom_addr;
   endtask

   task automatic wait_rise(input int budget, output logic [AW:0] a);
      int n0;
      n0 = n_rise;
      for (int i = 0; i < budget; i++) begin
         step();
         if (n_rise != n0) break;
      end
      chk("rise_timeout", n_rise - n0, 1);
      a = rise_addr;
   endtask

   task automatic wait_ok(input int req, input int budget, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         n++;
         if ((req == 1) ? scr_ok : obj_ok) begin
            got = 1'b1;
            break;
         end
      end
      chk("ok_timeout", got, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW:0] a;
      int n;
      int r0;
      mreset();
      // reset state, with requests present
      obj_cs = 1'b1; obj_addr = 13'h5;
      scr_cs = 1'b1; scr_addr = 13'h7;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_obj_ok", obj_ok, 0);
      chk("rst_scr_ok", scr_ok, 0);
      chk("rst_cs", rom_cs, 0);
      chk("rst_addr", rom_addr, 0);
      obj_cs = 1'b0; scr_cs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) step();

      // contention, three rounds: obj then scr each time
      for (int k = 0; k < 3; k++) begin
         obj_addr = 13'h0010 + 13'(k);
         scr_addr = 13'h1F00 + 13'(k);
         obj_cs = 1'b1; scr_cs = 1'b1;
         wait_rise(10, a);
         chk("arb_first", a, 14'h0010 + 14'(k));
         wait_rise(20, a);
         chk("arb_second", a, 14'h3F00 + 14'(k));
         wait_ok(1, 20, n);
      end
      obj_cs = 1'b0; scr_cs = 1'b0;
      repeat (3) step();

      // single request, ack 4 cycles after cs
      lat = 4;
      obj_addr = 13'h0123; obj_cs = 1'b1;
      step();
      chk("lat_cs", rom_cs, 1);
      chk("lat_addr", rom_addr, 14'h0123);
      wait_ok(0, 20, n);
      chk("lat_cycles", n, 4);
      chk("lat_data", obj_data, memfn(14'h0123));
      // result persists across cs drop, no new access
      r0 = n_rise;
      repeat (2) step();
      obj_cs = 1'b0;
      step();
      chk("hold_ok_low", obj_ok, 0);
      obj_cs = 1'b1;
      step();
      chk("hold_ok_high", obj_ok, 1);
      chk("hold_no_cs", rom_cs, 0);
      chk("hold_no_rise", n_rise, r0);

      // address change during the wait
      obj_addr = 13'h0040;
      wait_rise(10, a);
      step();
      obj_addr = 13'h0041;
      wait_rise(30, a);
      chk("chg_addr", a, 14'h0041);
      wait_ok(0, 30, n);
      chk("chg_data", obj_data, memfn(14'h0041));

      // stale ack on the first wait cycle
      repeat (2) step();
      stale = 1'b1; lat = 3;
      obj_addr = 13'h0055;
      wait_rise(10, a);
      wait_ok(0, 20, n);
      chk("stale_cycles", n, 3);
      chk("stale_data", obj_data, memfn(14'h0055));
      stale = 1'b0;

      // reset during a scr transaction
      obj_cs = 1'b0;
      repeat (2) step();
      lat = 6;
      scr_addr = 13'h0777; scr_cs = 1'b1;
      wait_rise(10, a);
      chk("rst_mid_addr", a, {B1, 13'h0777});
      step();
      #3;
      rst = 1'b1;
      #1;
      chk("rst_mid_cs", rom_cs, 0);
      chk("rst_mid_ok", scr_ok, 0);
      mreset();
      @(negedge clk);
      rst = 1'b0;
      wait_rise(10, a);
      chk("rst_reissue", a, {B1, 13'h0777});
      wait_ok(1, 20, n);

      // random traffic over a small address pool
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            obj_cs   = $urandom_range(0, 7) != 0;
            obj_addr = 13'h0100 + 13'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 3) == 0) begin
            scr_cs   = $urandom_range(0, 7) != 0;
            scr_addr = 13'h0A00 + 13'($urandom_range(0, 3));
         end
         if (!rom_cs) begin
            lat   = $urandom_range(2, 6);
            stale = $urandom_range(0, 3) == 0;
         end
         step();
      end
      obj_cs = 1'b0; scr_cs = 1'b0;
      repeat (12) step();
      chk("end_idle", rom_cs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
